alu_arbiter: RTL and testbench

- Shares one combinational ALU instance between NREQ requesters, e.g. an integer pipeline and an address/branch helper unit.
- Each requester uses a valid/ready request channel and a one-deep registered response channel.
- Grant is round-robin, at most one operation per cycle; result latency is 1 cycle.
- The ALU sits outside this block; the arbiter drives its operands and control and samples its result and zero outputs.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU control encoding shared by the ALU arbiter and the blocks that issue ALU ops.
package alu_pkg;

   localparam int ALU_CTRL_W = 3;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   // Codes 3'b110 and 3'b111 have no ALU operation behind them.
   function automatic logic is_legal_aluctrl(input logic [ALU_CTRL_W-1:0] ctrl);
      return (ctrl <= ALU_SLT);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after 'last', wrapping modulo N.
// Purely combinational (zero latency); requesters not picked simply stay pending.
// No backpressure of its own; callers gate req with their own resource-free terms.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      // k = N lands back on 'last' itself, so it only wins when nobody else asks.
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NREQ requesters, round-robin, one op per cycle.
// Latency 1 cycle into a one-deep response slot per requester; a slot accepts only when empty or draining.
// Backpressure: req_ready drops for a requester whose slot is full; ALU_ARB_ILLEGAL_CHK_EN traps ctrl 110/111.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*WIDTH-1:0]      req_a,
   input  logic [NREQ*WIDTH-1:0]      req_b,
   input  logic [NREQ*ALU_CTRL_W-1:0] req_ctrl,
   output logic [NREQ-1:0]            rsp_valid,
   input  logic [NREQ-1:0]            rsp_ready,
   output logic [NREQ*WIDTH-1:0]      rsp_result,
   output logic [NREQ-1:0]            rsp_zero,
   output logic [NREQ-1:0]            rsp_err,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [ALU_CTRL_W-1:0]      alu_ctrl,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic                       alu_zero
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]         last_grant;
   logic [IW-1:0]         grant_idx;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       eligible;
   logic                  gnt_any;
   logic                  drive_alu;
   logic [WIDTH-1:0]      sel_a;
   logic [WIDTH-1:0]      sel_b;
   logic [ALU_CTRL_W-1:0] sel_ctrl;

   // A full slot that is being drained this cycle can be refilled in the same cycle.
   assign eligible = req_valid & (~rsp_valid | rsp_ready);

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
      .req       (eligible),
      .last      (last_grant),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign gnt_any   = |grant;
   assign sel_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
   assign sel_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
   assign sel_ctrl  = req_ctrl[int'(grant_idx)*ALU_CTRL_W +: ALU_CTRL_W];

`ifdef ALU_ARB_ILLEGAL_CHK_EN
   logic illegal;
   assign illegal   = gnt_any && !is_legal_aluctrl(sel_ctrl);
   assign drive_alu = gnt_any && !illegal;
`else
   assign drive_alu = gnt_any;
   assign rsp_err   = '0;
`endif

   assign alu_a    = drive_alu ? sel_a    : '0;
   assign alu_b    = drive_alu ? sel_b    : '0;
   assign alu_ctrl = drive_alu ? sel_ctrl : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_zero   <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
         rsp_err    <= '0;
`endif
         last_grant <= IW'(NREQ - 1);
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
               rsp_valid[i] <= 1'b1;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
               rsp_result[i*WIDTH +: WIDTH] <= illegal ? '0   : alu_result;
               rsp_zero[i]                  <= illegal ? 1'b1 : alu_zero;
               rsp_err[i]                   <= illegal;
`else
               rsp_result[i*WIDTH +: WIDTH] <= alu_result;
               rsp_zero[i]                  <= alu_zero;
`endif
            end else if (rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
         if (gnt_any) begin
            last_grant <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;

   localparam int NREQ  = 2;
   localparam int WIDTH = 32;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             err;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*3-1:0]     req_ctrl;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [NREQ*WIDTH-1:0] rsp_result;
   logic [NREQ-1:0]       rsp_zero;
   logic [NREQ-1:0]       rsp_err;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [2:0]            alu_ctrl;
   logic [WIDTH-1:0]      alu_result;
   logic                  alu_zero;

   int n_cmp = 0;
   int n_err = 0;

   exp_t sb_q [NREQ][$];
   int   m_last = NREQ - 1;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ctrl   (req_ctrl),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

   function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   // External ALU the arbiter shares.
   always_comb begin
      alu_result = alu_f(alu_ctrl, alu_a, alu_b);
      alu_zero   = (alu_result == '0);
   end

   function automatic exp_t ref_rsp(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      if (c >= 3'd6) begin
         e.res = '0; e.zero = 1'b1; e.err = 1'b1;
         return e;
      end
`endif
      e.res  = alu_f(c, a, b);
      e.zero = (e.res == '0);
      e.err  = 1'b0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor / scoreboard: model occupancy, round-robin choice, ALU drive and responses.
   always @(negedge clk) begin
      logic [NREQ-1:0] elig;
      logic [NREQ-1:0] eg_vec;
      int              eg;
      logic [2:0]      c;
      logic [WIDTH-1:0] a, b;
      exp_t            e;
      if (reset) begin
         for (int i = 0; i < NREQ; i++) sb_q[i].delete();
         m_last = NREQ - 1;
      end else begin
         for (int i = 0; i < NREQ; i++)
            elig[i] = req_valid[i] && (sb_q[i].size() == 0 || rsp_ready[i]);
         eg = -1;
         for (int k = 1; k <= NREQ && eg < 0; k++)
            if (elig[(m_last + k) % NREQ]) eg = (m_last + k) % NREQ;
         eg_vec = '0;
         if (eg >= 0) eg_vec[eg] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(eg_vec));

         if (eg >= 0) begin
            c = req_ctrl[eg*3 +: 3];
            a = req_a[eg*WIDTH +: WIDTH];
            b = req_b[eg*WIDTH +: WIDTH];
         end else begin
            c = '0; a = '0; b = '0;
         end
`ifdef ALU_ARB_ILLEGAL_CHK_EN
         if (c >= 3'd6) begin c = '0; a = '0; b = '0; end
`endif
         chk("alu_drive", {29'd0, alu_ctrl, alu_a}, {29'd0, c, a});
         chk("alu_b", 64'(alu_b), 64'(b));

         for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]), 64'(sb_q[i].size() != 0));
            if (rsp_valid[i] && rsp_ready[i] && sb_q[i].size() != 0) begin
               e = sb_q[i].pop_front();
               chk($sformatf("result%0d", i), 64'(rsp_result[i*WIDTH +: WIDTH]), 64'(e.res));
               chk($sformatf("zero%0d", i), 64'(rsp_zero[i]), 64'(e.zero));
               chk($sformatf("err%0d", i), 64'(rsp_err[i]), 64'(e.err));
            end
         end
         if (eg >= 0) begin
            sb_q[eg].push_back(ref_rsp(req_ctrl[eg*3 +: 3], req_a[eg*WIDTH +: WIDTH], req_b[eg*WIDTH +: WIDTH]));
            m_last = eg;
         end
      end
   end

   task automatic issue(input int i, input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] er, input logic ez, input logic ee, input string nm);
      logic got = 1'b0;
      logic [NREQ-1:0] onehot = '0;
      onehot[i] = 1'b1;
      req_valid[i]            = 1'b1;
      req_ctrl[i*3 +: 3]      = c;
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      rsp_ready               = '1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            got = 1'b1;
            chk({nm, "_ready"}, 64'(req_ready), 64'(onehot));
         end
      end
      if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      @(negedge clk);
      chk({nm, "_valid"}, 64'(rsp_valid[i]), 64'd1);
      chk({nm, "_result"}, 64'(rsp_result[i*WIDTH +: WIDTH]), 64'(er));
      chk({nm, "_zero"}, 64'(rsp_zero[i]), 64'(ez));
      chk({nm, "_err"}, 64'(rsp_err[i]), 64'(ee));
      @(posedge clk); #1;
   endtask

   // Random traffic; fields held while a request waits, as requesters must.
   task automatic run(input int cycles, input int pv, input int pr, input logic hold0);
      logic [NREQ-1:0] acc;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc[i]) begin
               req_valid[i]            = ($urandom_range(0, 99) < pv);
               req_ctrl[i*3 +: 3]      = 3'($urandom_range(0, 7));
               req_a[i*WIDTH +: WIDTH] = $urandom;
               req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? req_a[i*WIDTH +: WIDTH] : $urandom;
            end
            rsp_ready[i] = ($urandom_range(0, 99) < pr);
         end
         if (hold0) rsp_ready[0] = 1'b0;
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_ctrl  = '0;
      rsp_ready = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_valid", 64'(rsp_valid), 64'd0);
      chk("reset_result", 64'(rsp_result), 64'd0);
      chk("reset_zero_err", 64'({rsp_zero, rsp_err}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      issue(0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add");
      issue(1, 3'd1, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, "sub");
      issue(0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, "slt");
      issue(1, 3'd4, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F, 1'b0, 1'b0, "xor");
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      issue(1, 3'd7, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "illegal");
      issue(1, 3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "legal_after");
`endif

      run(20, 100, 100, 1'b0);   // contention, alternating grants
      run(15, 100, 100, 1'b1);   // slot 0 blocked
      run(10, 100, 100, 1'b0);   // slot 0 released
      run(200, 60, 50, 1'b0);

      run(4, 100, 0, 1'b0);      // fill both slots
      reset     = 1'b1;
      req_valid = '1;
      rsp_ready = '1;
      @(posedge clk); #1;
      reset = 1'b0;
      run(10, 100, 100, 1'b0);
      run(300, 70, 70, 1'b0);
      run(10, 0, 100, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
